// File: rtl/obstacle_collision_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obstacle_collision_detector: pointer/obstacle hit detection, per-frame damage,
// HP, invulnerability window and game-over flag.  Rev 1.0
// ---------------------------------------------------------------------------
module obstacle_collision_detector #(
  parameter int MAX_HP        = 3,
  parameter int CURSOR_W      = 16,
  parameter int CURSOR_H      = 16,
  parameter int INVULN_FRAMES = 60,
  parameter int FRAME_VCOUNT  = 600
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_on,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic        hit,
  output logic [3:0]  hp,
  output logic        invulnerable,
  output logic        game_over
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_INVULN = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  localparam logic [3:0]  C_MAX_HP  = 4'(MAX_HP);
  localparam logic [7:0]  C_INV     = 8'(INVULN_FRAMES);
  localparam logic [11:0] C_FRAME_V = 12'(FRAME_VCOUNT);

  state_t      state_q, state_d;
  logic [3:0]  hp_q, hp_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic        hit_q, hit_d;
  logic        pend_q, pend_d;
  logic        overlap_q;

  logic        w_pix_valid;
  logic        w_overlap;
  logic        w_frame_tick;
  logic        w_frame_hit;
  logic [12:0] w_x_end;
  logic [12:0] w_y_end;

  // 13-bit upper bounds so a pointer near the right/bottom edge does not wrap
  assign w_x_end      = {1'b0, mouse_xpos} + 13'(CURSOR_W);
  assign w_y_end      = {1'b0, mouse_ypos} + 13'(CURSOR_H);
  assign w_pix_valid  = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
  assign w_overlap    = w_pix_valid
                     && (obstacle_x >= mouse_xpos) && ({1'b0, obstacle_x} < w_x_end)
                     && (obstacle_y >= mouse_ypos) && ({1'b0, obstacle_y} < w_y_end);
  assign w_frame_tick = (hcount_in == 12'd0) && (vcount_in == C_FRAME_V);
  assign w_frame_hit  = pend_q | overlap_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hp_q      <= C_MAX_HP;
      inv_cnt_q <= 8'd0;
      hit_q     <= 1'b0;
      pend_q    <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      inv_cnt_q <= inv_cnt_d;
      hit_q     <= hit_d;
      pend_q    <= pend_d;
      overlap_q <= w_overlap;
    end
  end

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    inv_cnt_d = inv_cnt_q;
    hit_d     = 1'b0;
    pend_d    = pend_q;

    if (!game_on) begin
      // Leaving the game wins over any damage decided in the same cycle
      state_d   = S_IDLE;
      hp_d      = C_MAX_HP;
      inv_cnt_d = 8'd0;
      pend_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hp_d    = C_MAX_HP;
          pend_d  = 1'b0;
          state_d = S_ARMED;
        end
        S_ARMED: begin
          if (w_frame_tick) begin
            pend_d = 1'b0;
            if (w_frame_hit) begin
              hit_d = 1'b1;
              if (hp_q <= 4'd1) begin
                hp_d    = 4'd0;
                state_d = S_DEAD;
              end else begin
                hp_d      = hp_q - 4'd1;
                inv_cnt_d = C_INV;
                state_d   = S_INVULN;
              end
            end
          end else if (overlap_q) begin
            pend_d = 1'b1;
          end
        end
        S_INVULN: begin
          pend_d = 1'b0;
          if (w_frame_tick) begin
            if (inv_cnt_q <= 8'd1) begin
              inv_cnt_d = 8'd0;
              state_d   = S_ARMED;
            end else begin
              inv_cnt_d = inv_cnt_q - 8'd1;
            end
          end
        end
        default: begin
          hp_d   = 4'd0;
          pend_d = 1'b0;
        end
      endcase
    end
  end

  assign hit          = hit_q;
  assign hp           = hp_q;
  assign invulnerable = (state_q == S_INVULN);
  assign game_over    = (state_q == S_DEAD);

endmodule
`default_nettype wire

// File: tb/tb_obstacle_collision_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_obstacle_collision_detector: directed vectors with hand-computed results,
// using short synthetic frames (tick = hcount 0, vcount 600).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_obstacle_collision_detector;

  logic        pclk = 1'b0;
  logic        rst;
  logic        game_on;
  logic [11:0] hcount_in, vcount_in;
  logic [11:0] obstacle_x, obstacle_y;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        hit;
  logic [3:0]  hp;
  logic        invulnerable;
  logic        game_over;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int hit_cnt  = 0;
  int hit_base = 0;
  logic hit_at_tick;

  obstacle_collision_detector dut (
    .pclk        (pclk),
    .rst         (rst),
    .game_on     (game_on),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .obstacle_x  (obstacle_x),
    .obstacle_y  (obstacle_y),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .hit         (hit),
    .hp          (hp),
    .invulnerable(invulnerable),
    .game_over   (game_over)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (hit === 1'b1) hit_cnt <= hit_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  // npix obstacle pixels along x, one quiet cycle, the tick, one trailing cycle
  task automatic run_frame(input int ox, input int oy, input int npix);
    for (int i = 0; i < npix; i++) begin
      obstacle_x = 12'(ox + i);
      obstacle_y = 12'(oy);
      cyc();
    end
    obstacle_x = 12'd0;
    obstacle_y = 12'd0;
    cyc();
    hcount_in = 12'd0;
    vcount_in = 12'd600;
    cyc();
    hcount_in   = 12'd1;
    vcount_in   = 12'd0;
    hit_at_tick = hit;
    cyc();
  endtask

  task automatic restart();
    game_on = 1'b0;
    cyc();
    game_on = 1'b1;
    cyc();
    hit_base = hit_cnt;
  endtask

  initial begin
    rst = 1'b1; game_on = 1'b0;
    hcount_in = 12'd1; vcount_in = 12'd0;
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    mouse_xpos = 12'd400; mouse_ypos = 12'd300;
    cyc(); cyc();
    chk("reset_hit", int'(hit), 0);
    chk("reset_hp", int'(hp), 3);
    chk("reset_inv", int'(invulnerable), 0);
    chk("reset_go", int'(game_over), 0);

    rst = 1'b0;
    game_on = 1'b1;
    cyc();
    hit_base = hit_cnt;

    // clean frames: obstacle far to the right of the pointer
    for (int f = 0; f < 3; f++) run_frame(651, 310, 21);
    chk("clean_hits", hit_cnt - hit_base, 0);
    chk("clean_hp", int'(hp), 3);
    chk("clean_inv", int'(invulnerable), 0);

    // single hit
    run_frame(410, 310, 1);
    chk("single_pulse_at_tick", int'(hit_at_tick), 1);
    chk("single_hits", hit_cnt - hit_base, 1);
    chk("single_pulse_width", int'(hit), 0);
    chk("single_hp", int'(hp), 2);
    chk("single_inv", int'(invulnerable), 1);

    // invulnerability window: 60 ticks of immunity
    hit_base = hit_cnt;
    for (int f = 0; f < 59; f++) run_frame(405, 305, 1);
    chk("inv_still_on_59", int'(invulnerable), 1);
    run_frame(405, 305, 1);
    chk("inv_off_60", int'(invulnerable), 0);
    chk("inv_no_hits", hit_cnt - hit_base, 0);
    chk("inv_hp", int'(hp), 2);
    run_frame(405, 305, 1);
    chk("post_inv_hit", hit_cnt - hit_base, 1);
    chk("post_inv_hp", int'(hp), 1);

    // edge geometry
    restart();
    chk("restart_hp", int'(hp), 3);
    run_frame(415, 315, 1);
    chk("edge_415_315", hit_cnt - hit_base, 1);
    restart();
    run_frame(416, 300, 1);
    chk("edge_416_300", hit_cnt - hit_base, 0);
    run_frame(400, 316, 1);
    chk("edge_400_316", hit_cnt - hit_base, 0);
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    run_frame(0, 0, 1);
    chk("edge_origin_none", hit_cnt - hit_base, 0);
    mouse_xpos = 12'd4090; mouse_ypos = 12'd300;
    run_frame(4095, 300, 1);
    chk("edge_x4095", hit_cnt - hit_base, 1);
    chk("edge_x4095_hp", int'(hp), 2);

    // death and restart
    mouse_xpos = 12'd400; mouse_ypos = 12'd300;
    restart();
    run_frame(410, 310, 1);
    for (int f = 0; f < 60; f++) run_frame(0, 0, 0);
    run_frame(410, 310, 1);
    for (int f = 0; f < 60; f++) run_frame(0, 0, 0);
    run_frame(410, 310, 1);
    chk("death_hits", hit_cnt - hit_base, 3);
    chk("death_hp", int'(hp), 0);
    chk("death_go", int'(game_over), 1);
    run_frame(410, 310, 3);
    chk("dead_no_hit", hit_cnt - hit_base, 3);
    chk("dead_hp", int'(hp), 0);
    restart();
    chk("revive_hp", int'(hp), 3);
    chk("revive_go", int'(game_over), 0);
    run_frame(410, 310, 1);
    chk("revive_armed_hit", hit_cnt - hit_base, 1);

    // overlap_r coincident with the tick counts for the closing frame
    restart();
    obstacle_x = 12'd410; obstacle_y = 12'd310;
    cyc();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    hcount_in = 12'd0; vcount_in = 12'd600;
    cyc();
    hcount_in = 12'd1; vcount_in = 12'd0;
    chk("tick_coincide_hit", int'(hit), 1);
    cyc();
    chk("tick_coincide_hp", int'(hp), 2);

    // game_on drop overrides a damage decision on the same tick
    restart();
    obstacle_x = 12'd410; obstacle_y = 12'd310;
    cyc();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    cyc();
    hcount_in = 12'd0; vcount_in = 12'd600; game_on = 1'b0;
    cyc();
    hcount_in = 12'd1; vcount_in = 12'd0;
    chk("gameoff_no_hit", int'(hit), 0);
    chk("gameoff_hp", int'(hp), 3);
    game_on = 1'b1;
    cyc();

    // reset in the middle of the invulnerability window
    restart();
    run_frame(410, 310, 1);
    for (int f = 0; f < 30; f++) run_frame(0, 0, 0);
    chk("midinv_inv", int'(invulnerable), 1);
    obstacle_x = 12'd410; obstacle_y = 12'd310;
    rst = 1'b1;
    cyc();
    chk("rst_hp", int'(hp), 3);
    chk("rst_inv", int'(invulnerable), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_go", int'(game_over), 0);
    rst = 1'b0;
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obstacle_collision_detector.md
Name: obstacle_collision_detector

Overview:
- Receiving end of the obstacle coordinate interface. Every obstacle module drives obstacle_x/obstacle_y with the pixel it is painting, or 0/0 when it paints nothing.
- This block compares those pixels against the mouse-pointer box, collects hits over each video frame, and applies damage at frame boundaries.
- It maintains player HP and an invulnerability window, and flags game over to the game-flow FSM.

Parameters:
- MAX_HP, 3, HP loaded on reset and on each game start (1..15).
- CURSOR_W, 16, pointer hit-box width in pixels.
- CURSOR_H, 16, pointer hit-box height in pixels.
- INVULN_FRAMES, 60, frames during which hits are ignored after taking damage (1..255).
- FRAME_VCOUNT, 600, vcount value that marks end of visible frame.

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- game_on  in  1  level; high while a game is running.
- hcount_in  in  12  current horizontal pixel counter.
- vcount_in  in  12  current vertical pixel counter.
- obstacle_x  in  12  x of obstacle pixel being drawn; 0 = none.
- obstacle_y  in  12  y of obstacle pixel being drawn; 0 = none.
- mouse_xpos  in  12  pointer top-left x.
- mouse_ypos  in  12  pointer top-left y.
- hit  out  1  one-cycle pulse when damage is applied.
- hp  out  4  current HP.
- invulnerable  out  1  high while in INVULN.
- game_over  out  1  high in DEAD.

Behaviour:
- Reset values:
  - hit=0, hp=MAX_HP, invulnerable=0, game_over=0.
  - State=IDLE, hit_pending=0, inv_cnt=0, overlap_r=0.
- Pixel valid: (obstacle_x!=0 || obstacle_y!=0).
- Overlap test:
  - mouse_xpos <= obstacle_x < mouse_xpos+CURSOR_W, and mouse_ypos <= obstacle_y < mouse_ypos+CURSOR_H.
  - Sums are computed 13 bits wide; no wrap at 4095.
- Overlap pipeline: the test result is registered into overlap_r, so it lags obstacle_x/y by 1 cycle.
- frame_tick: combinational, (hcount_in==0 && vcount_in==FRAME_VCOUNT). It is high for exactly one cycle per frame.
- hit_pending:
  - Sticky. Set by overlap_r in state ARMED.
  - Cleared in the cycle after any frame_tick, and on every state change.
- frame_hit = hit_pending | overlap_r, sampled in the frame_tick cycle. An overlap coincident with the tick counts for the closing frame.
- State IDLE:
  - Holds hp=MAX_HP, invulnerable=0, game_over=0.
  - game_on=1 moves to ARMED next cycle.
- State ARMED, on frame_tick with frame_hit=1:
  - Next cycle: hit=1 (one cycle), hp=hp-1.
  - If hp was 1: go to DEAD, hp=0.
  - Otherwise: go to INVULN, inv_cnt=INVULN_FRAMES.
- State ARMED, on frame_tick with frame_hit=0: no change.
- State INVULN:
  - overlap_r is ignored and hit_pending is held 0.
  - invulnerable=1.
  - Each frame_tick decrements inv_cnt. On the tick where inv_cnt==1, go to ARMED (invulnerable=0 next cycle).
  - The result is exactly INVULN_FRAMES ticks of immunity.
- State DEAD:
  - game_over=1, hp=0. Overlaps are ignored; hit never pulses.
  - Leaves only via game_on=0.
- game_on=0 in any state:
  - Go to IDLE next cycle, with hp=MAX_HP, invulnerable=0, game_over=0, hit=0.
  - This overrides a coincident frame_tick damage decision.
- rst mid-operation: all registers return to reset values the next edge, regardless of state or tick.
- hp never underflows; hit is never asserted in IDLE or DEAD.
- Latency: obstacle pixel at cycle t, then overlap_r at t+1, then damage at (first frame_tick ≥ t+1) + 1.

Test Plan:
- Clean frame: reset, game_on=1, mouse=(400,300); obstacle pixels only at x=651..671; run 3 frames -> hit never asserts, hp stays 3, invulnerable=0.
- Single hit: mouse=(400,300); one obstacle pixel (410,310) mid-frame -> exactly one hit pulse, 1 cycle after next frame_tick; hp=2; invulnerable=1.
- Invulnerability: after that hit, inject overlap (405,305) every frame for 60 frames -> no hit, hp=2; invulnerable falls after the 60th tick; overlap in frame 61 -> hit, hp=1.
- Edge geometry: mouse=(400,300) -> pixel (415,315) hits; (416,300) and (400,316) do not; obstacle (0,0) with mouse (0,0) does not. Mouse x=4090 with pixel (4095,300) hits (13-bit sum).
- Death and restart: three separated hits -> hp=0, game_over=1; further overlaps give no hit. Then game_on=0 for 1 cycle, then 1 -> hp=3, game_over=0, state ARMED.
- Tick coincidence and reset: overlap_r on the frame_tick cycle -> hit next cycle. Separately, assert rst while in INVULN with inv_cnt=30 -> next cycle hp=3, invulnerable=0, no hit.
